// File: rtl/approx_mult_pkg.sv
// Shared types and sizing helpers for the approximate sequential multiplier.
// Imported by approx_mult_seq and lod_trunc.
package approx_mult_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_KEEP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEP  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Width able to hold any count from 0 to 2*dw inclusive.
    function automatic int cnt_w(input int dw);
        return $clog2(2 * dw + 1);
    endfunction

endpackage

// File: rtl/lod_trunc.sv
// Leading-one detect and mantissa truncation for one operand.
// Purely combinational; reports dropped LSBs and worthless leading zeros.
module lod_trunc
    import approx_mult_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEEP_W = DEF_KEEP_W,
    parameter int CNT_W  = cnt_w(DEF_DATA_W)
) (
    input  logic [DATA_W-1:0] data,
    input  logic              round,
    output logic [KEEP_W-1:0] mant,
    output logic [CNT_W-1:0]  discarded,
    output logic [CNT_W-1:0]  worthless
);

    int lead;
    int sh;

    always_comb begin
        lead = 0;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                lead = i;
            end
        end
        sh = 0;
        if (lead >= KEEP_W) begin
            sh = lead - KEEP_W + 1;
        end
        discarded = CNT_W'(sh);
        mant = KEEP_W'(data >> sh);
        // Forcing the LSB recentres the truncation error around zero.
        if (round && sh != 0) begin
            mant[0] = 1'b1;
        end
        worthless = CNT_W'(DATA_W - KEEP_W) - discarded;
    end

endmodule

// File: rtl/approx_mult_seq.sv
// Approximate unsigned multiplier: truncate to KEEP_W-bit mantissas,
// shift-add multiply one bit per cycle, then rescale the product.
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEEP_W = DEF_KEEP_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [DATA_W-1:0]          data1_i,
    input  logic [DATA_W-1:0]          data2_i,
    input  logic                       round_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [2*DATA_W-1:0]        product_o,
    output logic [cnt_w(DATA_W)-1:0]   worthless_o,
    output logic [cnt_w(DATA_W)-1:0]   discarded_o
);

    localparam int CNT_W = cnt_w(DATA_W);
    localparam int PW    = 2 * DATA_W;
    localparam int AW    = 2 * KEEP_W;
    localparam int IW    = $clog2(KEEP_W + 1);

    state_t            state;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              rnd;
    logic [AW-1:0]     mc;
    logic [KEEP_W-1:0] mp;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_next;
    logic [IW-1:0]     cnt;

    logic [KEEP_W-1:0] mant1;
    logic [KEEP_W-1:0] mant2;
    logic [CNT_W-1:0]  disc1;
    logic [CNT_W-1:0]  disc2;
    logic [CNT_W-1:0]  worth1;
    logic [CNT_W-1:0]  worth2;

    lod_trunc #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .CNT_W (CNT_W)
    ) u_lod1 (
        .data     (op1),
        .round    (rnd),
        .mant     (mant1),
        .discarded(disc1),
        .worthless(worth1)
    );

    lod_trunc #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W),
        .CNT_W (CNT_W)
    ) u_lod2 (
        .data     (op2),
        .round    (rnd),
        .mant     (mant2),
        .discarded(disc2),
        .worthless(worth2)
    );

    assign ready_o  = (state == ST_IDLE);
    assign valid_o  = (state == ST_DONE);
    assign acc_next = mp[0] ? acc + mc : acc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            op1         <= '0;
            op2         <= '0;
            rnd         <= 1'b0;
            mc          <= '0;
            mp          <= '0;
            acc         <= '0;
            cnt         <= '0;
            product_o   <= '0;
            worthless_o <= '0;
            discarded_o <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        op1   <= data1_i;
                        op2   <= data2_i;
                        rnd   <= round_i;
                        state <= ST_SEP;
                    end
                end
                ST_SEP: begin
                    mc          <= AW'(mant1);
                    mp          <= mant2;
                    acc         <= '0;
                    cnt         <= '0;
                    worthless_o <= worth1 + worth2;
                    discarded_o <= disc1 + disc2;
                    state       <= ST_MUL;
                end
                ST_MUL: begin
                    // Final MUL cycle only rescales, keeping latency fixed.
                    if (cnt == IW'(KEEP_W)) begin
                        product_o <= PW'(acc) << discarded_o;
                        state     <= ST_DONE;
                    end else begin
                        acc <= acc_next;
                        mc  <= mc << 1;
                        mp  <= mp >> 1;
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_mult_seq.sv
// Directed vector bench for approx_mult_seq.
// Checks values, fixed latency, stall hold and mid-operation reset.
module tb_approx_mult_seq;

    localparam int DATA_W = 16;
    localparam int KEEP_W = 8;
    localparam int CNT_W  = 6;
    localparam int LAT    = KEEP_W + 2;

    logic              clk_i;
    logic              rst_ni;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic              round_i;
    logic              valid_o;
    logic              ready_i;
    logic [2*DATA_W-1:0] product_o;
    logic [CNT_W-1:0]  worthless_o;
    logic [CNT_W-1:0]  discarded_o;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        rnd;
        logic [31:0] prod;
        logic [5:0]  worth;
        logic [5:0]  disc;
    } vec_t;

    vec_t vecs[8];
    int n_run;
    int n_fail;

    approx_mult_seq #(
        .DATA_W(DATA_W),
        .KEEP_W(KEEP_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data1_i    (data1_i),
        .data2_i    (data2_i),
        .round_i    (round_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .product_o  (product_o),
        .worthless_o(worthless_o),
        .discarded_o(discarded_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int stall);
        int edges;
        @(negedge clk_i);
        check("ready_idle", ready_o, 1);
        valid_i = 1'b1;
        data1_i = v.a;
        data2_i = v.b;
        round_i = v.rnd;
        @(negedge clk_i);
        valid_i = 1'b0;
        data1_i = 16'hFFFF;
        data2_i = 16'hFFFF;
        round_i = ~v.rnd;
        edges = 0;
        while (valid_o !== 1'b1 && edges < 40) begin
            @(negedge clk_i);
            edges++;
        end
        check("latency", edges, LAT);
        check("product", product_o, v.prod);
        check("worthless", worthless_o, v.worth);
        check("discarded", discarded_o, v.disc);
        for (int s = 0; s < stall; s++) begin
            valid_i = s[0];
            data1_i = 16'h00FF;
            data2_i = 16'h0001;
            @(negedge clk_i);
            check("stall_ready", ready_o, 0);
            check("stall_valid", valid_o, 1);
            check("stall_prod", product_o, v.prod);
            check("stall_worth", worthless_o, v.worth);
            check("stall_disc", discarded_o, v.disc);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("release_valid", valid_o, 0);
        check("release_ready", ready_o, 1);
    endtask

    initial begin
        int seen;
        n_run   = 0;
        n_fail  = 0;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        round_i = 1'b0;
        data1_i = '0;
        data2_i = '0;

        vecs[0] = '{16'h00FF, 16'h0003, 1'b0, 32'h0000_02FD, 6'd16, 6'd0};
        vecs[1] = '{16'h1234, 16'h0100, 1'b0, 32'h0012_2000, 6'd10, 6'd6};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 32'h4000_0000, 6'd0, 6'd16};
        vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h4101_0000, 6'd0, 6'd16};
        vecs[4] = '{16'h0000, 16'hFFFF, 1'b0, 32'h0000_0000, 6'd8, 6'd8};
        vecs[5] = '{16'h00AB, 16'h00CD, 1'b1, 32'h0000_88EF, 6'd16, 6'd0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'hFE01_0000, 6'd0, 6'd16};
        vecs[7] = '{16'h0100, 16'h0100, 1'b1, 32'h0001_0404, 6'd14, 6'd2};

        #12;
        check("rst_ready", ready_o, 1);
        check("rst_valid", valid_o, 0);
        check("rst_prod", product_o, 0);
        check("rst_worth", worthless_o, 0);
        check("rst_disc", discarded_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 0);
        end

        run_vec(vecs[1], 5);

        @(negedge clk_i);
        valid_i = 1'b1;
        data1_i = 16'hFFFF;
        data2_i = 16'hFFFF;
        round_i = 1'b0;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_ready", ready_o, 1);
        check("mid_rst_valid", valid_o, 0);
        check("mid_rst_prod", product_o, 0);
        check("mid_rst_worth", worthless_o, 0);
        check("mid_rst_disc", discarded_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (valid_o === 1'b1 || ready_o !== 1'b1) begin
                seen++;
            end
        end
        check("no_ghost_result", seen, 0);

        run_vec(vecs[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
